// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the five-stage pipeline sequencer.
package pipeline_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam int DEF_MEM_TIMEOUT = 255;
  localparam int REG_W           = 5;

endpackage

// File: rtl/hazard_detect.sv
// Load-use detector: a load in EX whose destination feeds the instruction in ID.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic             ex_memread_i,
  input  logic [REG_W-1:0] ex_wrreg_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  output logic             load_use_o
);

  // $zero is never a real dependency.
  assign load_use_o = ex_memread_i && (ex_wrreg_i != '0) &&
                      ((ex_wrreg_i == id_rs_i) || (ex_wrreg_i == id_rt_i));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: stage enables/flushes, load-use bubbles, branch squash,
// data-memory wait freeze with timeout, and a saturating stall-cycle counter.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] ID_rs,
  input  logic [REG_W-1:0] ID_rt,
  input  logic             ID_jump,
  input  logic             EX_MemRead,
  input  logic [REG_W-1:0] EX_WrReg,
  input  logic             EX_BranchTaken,
  input  logic             Mem_MemRead,
  input  logic             Mem_MemWrite,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             IFID_en,
  output logic             IDEX_en,
  output logic             EXMEM_en,
  output logic             MEMWB_en,
  output logic             IFID_flush,
  output logic             IDEX_flush,
  output logic             MEMWB_flush,
  output logic             dmem_req,
  output logic             bus_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int                WCNT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] TIMEOUT_V = WCNT_W'(MEM_TIMEOUT);
  localparam logic [WCNT_W-1:0] LAST_V    = WCNT_W'(MEM_TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic               bus_err_q, bus_err_d;
  logic [CNT_W-1:0]   stall_q, stall_d;

  logic mem_access;
  logic timed_out;
  logic freeze;
  logic load_use;

  hazard_detect u_hazard (
    .ex_memread_i (EX_MemRead),
    .ex_wrreg_i   (EX_WrReg),
    .id_rs_i      (ID_rs),
    .id_rt_i      (ID_rt),
    .load_use_o   (load_use)
  );

  assign mem_access = Mem_MemRead || Mem_MemWrite;
  assign timed_out  = (state_q == MEM_WAIT) && (wcnt_q >= TIMEOUT_V);
  // The first not-ready cycle already freezes, so an N-cycle wait costs N frozen cycles.
  assign freeze     = mem_access && !dmem_ready && !timed_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      wcnt_q    <= '0;
      bus_err_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      bus_err_q <= bus_err_d;
      stall_q   <= stall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = '0;
    unique case (state_q)
      RUN: begin
        if (freeze) begin
          state_d = MEM_WAIT;
          wcnt_d  = WCNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (freeze) wcnt_d = wcnt_q + WCNT_W'(1);
        else        state_d = RUN;
      end
    endcase
    // Raised on the edge where the counter reaches the limit, so it lines up with the release cycle.
    bus_err_d = freeze && (wcnt_q == LAST_V);
    stall_d   = (!pc_en && (stall_q != '1)) ? stall_q + CNT_W'(1) : stall_q;
  end

  always_comb begin
    pc_en       = 1'b1;
    IFID_en     = 1'b1;
    IDEX_en     = 1'b1;
    EXMEM_en    = 1'b1;
    MEMWB_en    = 1'b1;
    IFID_flush  = 1'b0;
    IDEX_flush  = 1'b0;
    MEMWB_flush = 1'b0;
    dmem_req    = mem_access;
    if (freeze) begin
      pc_en       = 1'b0;
      IFID_en     = 1'b0;
      IDEX_en     = 1'b0;
      EXMEM_en    = 1'b0;
      MEMWB_flush = 1'b1;
    end else if (EX_BranchTaken) begin
      // Wrong-path instructions in IF and ID are squashed; any load-use on them is moot.
      IFID_flush = 1'b1;
      IDEX_flush = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      IFID_en    = 1'b0;
      IDEX_flush = 1'b1;
    end else if (ID_jump) begin
      IFID_flush = 1'b1;
    end
    if (!reset) begin
      pc_en       = 1'b0;
      IFID_en     = 1'b0;
      IDEX_en     = 1'b0;
      EXMEM_en    = 1'b0;
      MEMWB_en    = 1'b0;
      IFID_flush  = 1'b0;
      IDEX_flush  = 1'b0;
      MEMWB_flush = 1'b0;
      dmem_req    = 1'b0;
    end
  end

  assign bus_err      = bus_err_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scenario bench for pipeline_ctrl: per-cycle expected output vectors are queued
// as stimulus is applied and compared when the cycle is sampled.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ID_rs, ID_rt, EX_WrReg;
  logic       ID_jump, EX_MemRead, EX_BranchTaken;
  logic       Mem_MemRead, Mem_MemWrite, dmem_ready;
  logic       pc_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en;
  logic       IFID_flush, IDEX_flush, MEMWB_flush, dmem_req, bus_err;
  logic [4:0] stall_cycles;

  // {pc,IFID,IDEX,EXMEM,MEMWB en | IFID,IDEX,MEMWB flush | dmem_req | bus_err}
  localparam logic [9:0] ZERO   = 10'b00000_000_0_0;
  localparam logic [9:0] RUNV   = 10'b11111_000_0_0;
  localparam logic [9:0] RUNREQ = 10'b11111_000_1_0;
  localparam logic [9:0] FRZ    = 10'b00001_001_1_0;
  localparam logic [9:0] LU     = 10'b00111_010_0_0;
  localparam logic [9:0] BR     = 10'b11111_110_0_0;
  localparam logic [9:0] BRREQ  = 10'b11111_110_1_0;
  localparam logic [9:0] JMP    = 10'b11111_100_0_0;
  localparam logic [9:0] RELERR = 10'b11111_000_1_1;

  int         n_chk  = 0;
  int         n_fail = 0;
  logic [9:0] sb[$];
  logic [9:0] exp_v;
  logic [4:0] sc_model = '0;

  pipeline_ctrl #(.MEM_TIMEOUT(8), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_jump(ID_jump),
    .EX_MemRead(EX_MemRead), .EX_WrReg(EX_WrReg), .EX_BranchTaken(EX_BranchTaken),
    .Mem_MemRead(Mem_MemRead), .Mem_MemWrite(Mem_MemWrite), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .IFID_en(IFID_en), .IDEX_en(IDEX_en), .EXMEM_en(EXMEM_en),
    .MEMWB_en(MEMWB_en), .IFID_flush(IFID_flush), .IDEX_flush(IDEX_flush),
    .MEMWB_flush(MEMWB_flush), .dmem_req(dmem_req), .bus_err(bus_err),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] outs();
    return {pc_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en,
            IFID_flush, IDEX_flush, MEMWB_flush, dmem_req, bus_err};
  endfunction

  function automatic logic [4:0] stall_next(logic [4:0] s, logic [9:0] v);
    if (!v[9] && s != 5'h1f) return s + 5'd1;
    return s;
  endfunction

  task automatic quiet();
    ID_rs = 0; ID_rt = 0; EX_WrReg = 0; ID_jump = 0; EX_MemRead = 0;
    EX_BranchTaken = 0; Mem_MemRead = 0; Mem_MemWrite = 0; dmem_ready = 0;
  endtask

  task automatic test_reset();
    quiet();
    reset = 1'b0; Mem_MemRead = 1'b1; dmem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 3) begin reset = 1'b1; sb.push_back(RUNREQ); end
      else sb.push_back(ZERO);
      #2;
      exp_v = sb.pop_front();
      n_chk++;
      if (outs() !== exp_v) begin n_fail++; $display("FAIL reset[%0d] outputs: got %b want %b", i, outs(), exp_v); end
      n_chk++;
      if (stall_cycles !== sc_model) begin n_fail++; $display("FAIL reset[%0d] stall_cycles: got %0d want %0d", i, stall_cycles, sc_model); end
      if (reset) sc_model = stall_next(sc_model, exp_v);
    end
  endtask

  task automatic test_load_use();
    bit         mr[7] = '{1, 0, 1, 0, 1, 1, 0};
    int         wr[7] = '{8, 8, 9, 9, 0, 8, 8};
    int         rs[7] = '{8, 8, 1, 1, 0, 7, 8};
    int         rt[7] = '{3, 3, 9, 9, 0, 9, 8};
    logic [9:0] ev[7] = '{LU, RUNV, LU, RUNV, RUNV, RUNV, RUNV};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      quiet();
      EX_MemRead = mr[i]; EX_WrReg = 5'(wr[i]); ID_rs = 5'(rs[i]); ID_rt = 5'(rt[i]);
      sb.push_back(ev[i]);
      #2;
      exp_v = sb.pop_front();
      n_chk++;
      if (outs() !== exp_v) begin n_fail++; $display("FAIL load_use[%0d] outputs: got %b want %b", i, outs(), exp_v); end
      n_chk++;
      if (stall_cycles !== sc_model) begin n_fail++; $display("FAIL load_use[%0d] stall_cycles: got %0d want %0d", i, stall_cycles, sc_model); end
      sc_model = stall_next(sc_model, exp_v);
    end
  endtask

  task automatic test_mem_wait();
    logic [4:0] start = sc_model;
    int         bubbles = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      quiet();
      Mem_MemWrite = (i < 5); dmem_ready = (i == 4);
      sb.push_back(i < 4 ? FRZ : (i == 4 ? RUNREQ : RUNV));
      #2;
      exp_v = sb.pop_front();
      if (MEMWB_en && MEMWB_flush) bubbles++;
      n_chk++;
      if (outs() !== exp_v) begin n_fail++; $display("FAIL mem_wait[%0d] outputs: got %b want %b", i, outs(), exp_v); end
      n_chk++;
      if (stall_cycles !== sc_model) begin n_fail++; $display("FAIL mem_wait[%0d] stall_cycles: got %0d want %0d", i, stall_cycles, sc_model); end
      sc_model = stall_next(sc_model, exp_v);
    end
    n_chk++;
    if (stall_cycles !== start + 5'd4) begin n_fail++; $display("FAIL mem_wait stall_delta: got %0d want %0d", stall_cycles, start + 5'd4); end
    n_chk++;
    if (bubbles != 4) begin n_fail++; $display("FAIL mem_wait memwb_bubbles: got %0d want 4", bubbles); end
  endtask

  task automatic test_timeout();
    int pulses = 0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      quiet();
      Mem_MemRead = (i < 9);
      sb.push_back(i < 8 ? FRZ : (i == 8 ? RELERR : RUNV));
      #2;
      exp_v = sb.pop_front();
      if (bus_err) pulses++;
      n_chk++;
      if (outs() !== exp_v) begin n_fail++; $display("FAIL timeout[%0d] outputs: got %b want %b", i, outs(), exp_v); end
      n_chk++;
      if (stall_cycles !== sc_model) begin n_fail++; $display("FAIL timeout[%0d] stall_cycles: got %0d want %0d", i, stall_cycles, sc_model); end
      sc_model = stall_next(sc_model, exp_v);
    end
    n_chk++;
    if (pulses != 1) begin n_fail++; $display("FAIL timeout bus_err_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_priority();
    bit         lu[5] = '{1, 0, 1, 0, 0};
    bit         br[5] = '{1, 0, 0, 1, 0};
    bit         jp[5] = '{0, 1, 1, 1, 0};
    logic [9:0] ev[5] = '{BR, JMP, LU, BR, RUNV};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      quiet();
      EX_MemRead = lu[i]; EX_WrReg = 5'd12; ID_rt = 5'd12; ID_rs = 5'd4;
      EX_BranchTaken = br[i]; ID_jump = jp[i];
      sb.push_back(ev[i]);
      #2;
      exp_v = sb.pop_front();
      n_chk++;
      if (outs() !== exp_v) begin n_fail++; $display("FAIL priority[%0d] outputs: got %b want %b", i, outs(), exp_v); end
      n_chk++;
      if (stall_cycles !== sc_model) begin n_fail++; $display("FAIL priority[%0d] stall_cycles: got %0d want %0d", i, stall_cycles, sc_model); end
      sc_model = stall_next(sc_model, exp_v);
    end
  endtask

  task automatic test_branch_in_wait();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      quiet();
      Mem_MemRead = (i < 4); dmem_ready = (i == 3); EX_BranchTaken = (i < 4);
      sb.push_back(i < 3 ? FRZ : (i == 3 ? BRREQ : RUNV));
      #2;
      exp_v = sb.pop_front();
      n_chk++;
      if (outs() !== exp_v) begin n_fail++; $display("FAIL branch_in_wait[%0d] outputs: got %b want %b", i, outs(), exp_v); end
      n_chk++;
      if (stall_cycles !== sc_model) begin n_fail++; $display("FAIL branch_in_wait[%0d] stall_cycles: got %0d want %0d", i, stall_cycles, sc_model); end
      sc_model = stall_next(sc_model, exp_v);
    end
  endtask

  task automatic test_reset_mid_wait();
    // 3 frozen, 2 in reset, then a fresh full-length wait that must time out after 8.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      quiet();
      reset = !(i == 3 || i == 4);
      Mem_MemRead = (i < 14);
      if (!reset) sb.push_back(ZERO);
      else if (i < 3 || (i >= 5 && i < 13)) sb.push_back(FRZ);
      else if (i == 13) sb.push_back(RELERR);
      else sb.push_back(RUNV);
      if (!reset) sc_model = '0;
      #2;
      exp_v = sb.pop_front();
      n_chk++;
      if (outs() !== exp_v) begin n_fail++; $display("FAIL reset_mid_wait[%0d] outputs: got %b want %b", i, outs(), exp_v); end
      n_chk++;
      if (stall_cycles !== sc_model) begin n_fail++; $display("FAIL reset_mid_wait[%0d] stall_cycles: got %0d want %0d", i, stall_cycles, sc_model); end
      if (reset) sc_model = stall_next(sc_model, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    // Access held with memory never ready: repeated 8-frozen / 1-release windows.
    for (int i = 0; i < 41; i++) begin
      @(negedge clk);
      quiet();
      Mem_MemWrite = (i < 40);
      sb.push_back(i == 40 ? RUNV : ((i % 9) < 8 ? FRZ : RELERR));
      #2;
      exp_v = sb.pop_front();
      n_chk++;
      if (outs() !== exp_v) begin n_fail++; $display("FAIL back_to_back[%0d] outputs: got %b want %b", i, outs(), exp_v); end
      n_chk++;
      if (stall_cycles !== sc_model) begin n_fail++; $display("FAIL back_to_back[%0d] stall_cycles: got %0d want %0d", i, stall_cycles, sc_model); end
      sc_model = stall_next(sc_model, exp_v);
    end
    n_chk++;
    if (stall_cycles !== 5'h1f) begin n_fail++; $display("FAIL stall_saturation: got %0d want 31", stall_cycles); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_use();
    test_mem_wait();
    test_timeout();
    test_priority();
    test_branch_in_wait();
    test_reset_mid_wait();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
